// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit: radix-2 Booth multiply and restoring
// divide on magnitudes, one step per cycle, results in HI/LO.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic              dz_q, dz_d;
  logic [2*WIDTH:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  m_q, m_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // Accumulator is {A, Q, q-1}. The add is done one bit wider so that
  // subtracting the most negative multiplicand cannot overflow before the shift.
  function automatic logic [2*WIDTH:0] booth_step(input logic [2*WIDTH:0] acc,
                                                  input logic signed [WIDTH-1:0] m);
    logic signed [WIDTH:0] upper;
    logic signed [WIDTH:0] sum;
    upper = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    case (acc[1:0])
      2'b01:   sum = upper + {m[WIDTH-1], m};
      2'b10:   sum = upper - {m[WIDTH-1], m};
      default: sum = upper;
    endcase
    return {sum, acc[WIDTH:1]};
  endfunction

  // Accumulator is {remainder (WIDTH+1), quotient (WIDTH)}.
  function automatic logic [2*WIDTH:0] div_step(input logic [2*WIDTH:0] acc,
                                                input logic [WIDTH-1:0] d);
    logic [WIDTH:0] rs;
    logic [WIDTH:0] trial;
    logic [2*WIDTH:0] res;
    rs    = acc[2*WIDTH-1:WIDTH-1];
    trial = rs - {1'b0, d};
    if (!trial[WIDTH]) res = {trial, acc[WIDTH-2:0], 1'b1};
    else               res = {rs, acc[WIDTH-2:0], 1'b0};
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = 1'b0;
    acc_d   = acc_q;
    m_d     = m_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    case (state_q)
      IDLE: begin
        if (start_mult) begin
          state_d = MULT;
          cnt_d   = CW'(WIDTH);
          m_d     = a_in;
          acc_d   = {{WIDTH{1'b0}}, b_in, 1'b0};
        end else if (start_div) begin
          if (b_in == '0) begin
            state_d = DONE;
            dz_d    = 1'b1;
          end else begin
            state_d = DIV;
            cnt_d   = CW'(WIDTH);
            m_d     = mag(b_in);
            acc_d   = {{(WIDTH+1){1'b0}}, mag(a_in)};
            qneg_d  = a_in[WIDTH-1] ^ b_in[WIDTH-1];
            rneg_d  = a_in[WIDTH-1];
          end
        end
      end
      MULT: begin
        if (cnt_q != '0) begin
          acc_d = booth_step(acc_q, m_q);
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = DONE;
          hi_d    = acc_q[2*WIDTH:WIDTH+1];
          lo_d    = acc_q[WIDTH:1];
        end
      end
      DIV: begin
        if (cnt_q != '0) begin
          acc_d = div_step(acc_q, m_q);
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Remainder follows the dividend's sign; quotient truncates toward zero.
          state_d = DONE;
          lo_d    = apply_sign(acc_q[WIDTH-1:0], qneg_q);
          hi_d    = apply_sign(acc_q[2*WIDTH-1:WIDTH], rneg_q);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  // Datapath registers are always reloaded by a start, so they carry no reset.
  always_ff @(posedge clock) begin
    acc_q  <= acc_d;
    m_q    <= m_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign div_zero = dz_q;

endmodule
